snake_body_tracker: RTL



---
 rtl/snake_pkg.sv | 13 +
 rtl/snake_next_head.sv | 24 ++
 rtl/snake_body_tracker.sv | 90 +++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: direction encoding, grid limits, FSM state type and direction helper
package snake_pkg;
  localparam logic [1:0] DIR_UP = 2'd0;
  localparam logic [1:0] DIR_DOWN = 2'd1;
  localparam logic [1:0] DIR_LEFT = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;
  localparam int X_MAX = 39;
  localparam int Y_MAX = 29;
  typedef enum logic {ST_RUN, ST_DEAD} state_t;
  function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
    return (a ^ b) == 2'b01;
  endfunction
endpackage

// File: rtl/snake_next_head.sv
// snake_next_head: next head cell for a direction, plus wall-hit flag
module snake_next_head #(
  parameter int XW = 6,
  parameter int YW = 5,
  parameter int X_MAX = snake_pkg::X_MAX,
  parameter int Y_MAX = snake_pkg::Y_MAX
) (
  input  logic [XW-1:0] head_x,
  input  logic [YW-1:0] head_y,
  input  logic [1:0]    dir,
  output logic [XW-1:0] nxt_x,
  output logic [YW-1:0] nxt_y,
  output logic          wall
);
  import snake_pkg::*;
  // unsigned +-1 is safe because a wall hit suppresses the move
  always_comb begin
    nxt_x = dir == DIR_LEFT ? head_x - XW'(1) : dir == DIR_RIGHT ? head_x + XW'(1) : head_x;
    nxt_y = dir == DIR_UP ? head_y - YW'(1) : dir == DIR_DOWN ? head_y + YW'(1) : head_y;
    wall = dir == DIR_UP ? head_y == '0 :
           dir == DIR_DOWN ? head_y == YW'(Y_MAX) :
           dir == DIR_LEFT ? head_x == '0 : head_x == XW'(X_MAX);
  end
endmodule

// File: rtl/snake_body_tracker.sv
// snake_body_tracker: segment shift register, growth, wall death FSM
module snake_body_tracker #(
  parameter int MAX_LEN = 20,
  parameter int XW = 6,
  parameter int YW = 5,
  parameter int X_MAX = snake_pkg::X_MAX,
  parameter int Y_MAX = snake_pkg::Y_MAX,
  parameter int INIT_LEN = 3,
  parameter int INIT_X = 20,
  parameter int INIT_Y = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step,
  input  logic [1:0]            dir_in,
  input  logic                  grow,
  output logic [MAX_LEN*XW-1:0] seg_x,
  output logic [MAX_LEN*YW-1:0] seg_y,
  output logic [MAX_LEN-1:0]    seg_en,
  output logic [XW-1:0]         head_x,
  output logic [YW-1:0]         head_y,
  output logic [4:0]            length,
  output logic                  moved,
  output logic                  dead
);
  import snake_pkg::*;
  logic [XW-1:0] xs [MAX_LEN];
  logic [YW-1:0] ys [MAX_LEN];
  logic [XW-1:0] nxt_x;
  logic [YW-1:0] nxt_y;
  logic [1:0] cur_dir, eff_dir;
  logic grow_pend, wall, go;
  state_t state, state_d;
  snake_next_head #(.XW(XW), .YW(YW), .X_MAX(X_MAX), .Y_MAX(Y_MAX)) u_next_head (
    .head_x(xs[0]),
    .head_y(ys[0]),
    .dir(eff_dir),
    .nxt_x(nxt_x),
    .nxt_y(nxt_y),
    .wall(wall)
  );
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_pack
    assign seg_x[i*XW +: XW] = xs[i];
    assign seg_y[i*YW +: YW] = ys[i];
  end
  assign head_x = xs[0];
  assign head_y = ys[0];
  // a reversal request is dropped so the head never folds back onto the neck
  always_comb begin
    eff_dir = is_reverse(dir_in, cur_dir) ? cur_dir : dir_in;
    go = state == ST_RUN && step && !wall;
    state_d = state == ST_RUN && step && wall ? ST_DEAD : state;
  end
  // body shift, growth bookkeeping and state register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        xs[i] <= i < INIT_LEN ? XW'(INIT_X - i) : '0;
        ys[i] <= i < INIT_LEN ? YW'(INIT_Y) : '0;
      end
      seg_en <= {MAX_LEN{1'b1}} >> (MAX_LEN - INIT_LEN);
      length <= 5'(INIT_LEN);
      cur_dir <= DIR_RIGHT;
      grow_pend <= 1'b0;
      moved <= 1'b0;
      dead <= 1'b0;
      state <= ST_RUN;
    end else begin
      state <= state_d;
      dead <= state_d == ST_DEAD;
      moved <= go;
      if (state == ST_RUN && step) cur_dir <= eff_dir;
      if (go) begin
        for (int i = 1; i < MAX_LEN; i++) begin
          xs[i] <= xs[i-1];
          ys[i] <= ys[i-1];
        end
        xs[0] <= nxt_x;
        ys[0] <= nxt_y;
        if ((grow_pend || grow) && length < 5'(MAX_LEN)) begin
          seg_en <= seg_en | (MAX_LEN'(1) << length);
          length <= length + 5'd1;
        end
        grow_pend <= 1'b0;
      end else if (state == ST_RUN && grow) begin
        grow_pend <= 1'b1;
      end
    end
  end
endmodule
